// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//
// This is the pipeline register between instruction decode and the ALU/execute
// stage. It holds two entries:
//   - The main entry drives out_*.
//   - The skid entry absorbs one extra bundle while execute stalls.
// Every output comes straight from a flop. A stall in execute therefore never
// reaches decode combinationally.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous kill of both entries (branch/jump redirect)
//   in_valid/in_ready   decode-side handshake; in_ready is registered (!skid)
//   in_alu_op .. in_reg_write
//                       operand/destination bundle from decode
//   out_valid/out_ready execute-side handshake
//   out_alu_op .. out_reg_write
//                       registered bundle from the main entry
//
// Optional feature (macro ID_EX_WB_FWD_EN)
//   This macro adds the ports in_rs1, in_rs2, in_in2_is_reg, wb_we, wb_rd and
//   wb_data. A bundle captured from the input side takes wb_data in place of a
//   register operand when the writeback targets that operand's source
//   register. Bundles that are already buffered are left as they are.
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,

    // Decode side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_alu_op,
    input  logic [XLEN-1:0] in_in1,
    input  logic [XLEN-1:0] in_in2,
    input  logic [6:0]      in_funct7,
    input  logic [4:0]      in_shamt,
    input  logic            in_is_r_type,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_reg_write,
`ifdef ID_EX_WB_FWD_EN
    input  logic [RD_W-1:0] in_rs1,
    input  logic [RD_W-1:0] in_rs2,
    input  logic            in_in2_is_reg,
    input  logic            wb_we,
    input  logic [RD_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif

    // Execute side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_alu_op,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_shamt,
    output logic            out_is_r_type,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write
);

    typedef struct packed {
        logic [2:0]      alu_op;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [6:0]      funct7;
        logic [4:0]      shamt;
        logic            is_r_type;
        logic [RD_W-1:0] rd;
        logic            reg_write;
    } bundle_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;

    // -----------------------------------------------------------------------
    // Incoming bundle, with optional writeback forwarding applied at capture
    // -----------------------------------------------------------------------
    bundle_t in_bundle;

`ifdef ID_EX_WB_FWD_EN
    logic fwd_rs1;
    logic fwd_rs2;

    always_comb begin
        fwd_rs1 = wb_we && (wb_rd != '0) && (wb_rd == in_rs1);
        fwd_rs2 = wb_we && (wb_rd != '0) && in_in2_is_reg && (wb_rd == in_rs2);
    end
`endif

    always_comb begin
        in_bundle.alu_op    = in_alu_op;
        in_bundle.in1       = in_in1;
        in_bundle.in2       = in_in2;
        in_bundle.funct7    = in_funct7;
        in_bundle.shamt     = in_shamt;
        in_bundle.is_r_type = in_is_r_type;
        in_bundle.rd        = in_rd;
        in_bundle.reg_write = in_reg_write;
`ifdef ID_EX_WB_FWD_EN
        if (fwd_rs1) begin
            in_bundle.in1 = wb_data;
        end
        if (fwd_rs2) begin
            in_bundle.in2 = wb_data;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    logic in_fire;
    logic out_fire;

    // The skid entry is only ever occupied while the main entry is full. So a
    // free skid entry guarantees room, whatever execute does this cycle.
    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;

        if (flush) begin
            // Redirect: drop everything, including any bundle offered this
            // cycle. Payload flops keep stale data.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_d       = in_bundle;
            end
        end else if (out_fire) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no new bundle can compete.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d = in_bundle;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = in_bundle;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_valid     = main_valid_q;
    assign out_alu_op    = main_q.alu_op;
    assign out_in1       = main_q.in1;
    assign out_in2       = main_q.in2;
    assign out_funct7    = main_q.funct7;
    assign out_shamt     = main_q.shamt;
    assign out_is_r_type = main_q.is_r_type;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write;

endmodule
